// File: rtl/peg_draw_ctrl.sv
// Peg-draw request controller: accepts one (row, slot, colour) request, converts it to
// screen coordinates and sequences the datapath load/draw strobes for one 4x4 peg.
module peg_draw_ctrl #(
    parameter int unsigned BOARD_X0   = 8,
    parameter int unsigned BOARD_Y0   = 4,
    parameter int unsigned SLOT_PITCH = 6,
    parameter int unsigned ROW_PITCH  = 7,
    parameter int unsigned NUM_ROWS   = 10,
    parameter int unsigned PEG_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    input  logic [3:0] req_row,
    input  logic [1:0] req_slot,
    input  logic [2:0] req_colour,
    output logic       req_ready,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic       dp_write,
    output logic       dp_draw,
    output logic       dp_rest,
    output logic       plot,
    output logic [2:0] colour_out,
    output logic       done,
    output logic       err
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [X_W-1:0]   r_x;
    logic [X_W-1:0]   w_x_nxt;
    logic [Y_W-1:0]   r_y;
    logic [Y_W-1:0]   w_y_nxt;
    logic [2:0]       r_colour;
    logic [2:0]       w_colour_nxt;
    logic             r_dp_write;
    logic             w_dp_write_nxt;
    logic             r_dp_draw;
    logic             w_dp_draw_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic             w_accept;
    logic             w_row_bad;
    logic [X_W-1:0]   w_x_calc;
    logic [Y_W-1:0]   w_y_calc;

    // Ready is suppressed for the single cycle in which a rejection is reported.
    assign w_accept  = req_valid && (r_state == S_IDLE) && !r_err;
    assign w_row_bad = 32'(req_row) >= NUM_ROWS;
    assign w_x_calc  = X_W'(BOARD_X0 + SLOT_PITCH * 32'(req_slot));
    assign w_y_calc  = Y_W'(BOARD_Y0 + ROW_PITCH * 32'(req_row));

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_colour_nxt   = r_colour;
        w_dp_write_nxt = 1'b0;
        w_dp_draw_nxt  = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_row_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = S_LOAD;
                        w_dp_write_nxt = 1'b1;
                        w_x_nxt        = w_x_calc;
                        w_y_nxt        = w_y_calc;
                        w_colour_nxt   = req_colour;
                    end
                end
            end
            S_LOAD: begin
                w_state_nxt   = S_DRAW;
                w_cnt_nxt     = CNT_W'(PEG_CYCLES - 1);
                w_dp_draw_nxt = 1'b1;
            end
            S_DRAW: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_FIN;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt - CNT_W'(1);
                    w_dp_draw_nxt = 1'b1;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_colour   <= '0;
            r_dp_write <= 1'b0;
            r_dp_draw  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_colour   <= w_colour_nxt;
            r_dp_write <= w_dp_write_nxt;
            r_dp_draw  <= w_dp_draw_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Counter clear is held during reset as well as in LOAD.
    assign dp_rest    = r_dp_write || !resetn;
    assign req_ready  = resetn && (r_state == S_IDLE) && !r_err;
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign dp_write   = r_dp_write;
    assign dp_draw    = r_dp_draw;
    assign plot       = r_dp_draw;
    assign colour_out = r_colour;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_peg_draw_ctrl.sv
// Directed and randomised checks of peg_draw_ctrl timing, coordinates and strobes.
module tb_peg_draw_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic [3:0] req_row;
    logic [1:0] req_slot;
    logic [2:0] req_colour;
    logic       req_ready;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic       dp_write;
    logic       dp_draw;
    logic       dp_rest;
    logic       plot;
    logic [2:0] colour_out;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    logic mon_en = 1'b0;
    int   mon_plot = 0;
    int   mon_overlap = 0;

    peg_draw_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_row    (req_row),
        .req_slot   (req_slot),
        .req_colour (req_colour),
        .req_ready  (req_ready),
        .x_out      (x_out),
        .y_out      (y_out),
        .dp_write   (dp_write),
        .dp_draw    (dp_draw),
        .dp_rest    (dp_rest),
        .plot       (plot),
        .colour_out (colour_out),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Plot-cycle and strobe-overlap counters for the random phase.
    always @(negedge clk) begin
        if (mon_en) begin
            if (plot) mon_plot++;
            if (dp_write && dp_draw) mon_overlap++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; req_row = '0; req_slot = '0; req_colour = '0;
        tick(); tick();
        n_checks++; if (x_out !== 8'd0 || y_out !== 7'd0 || colour_out !== 3'd0) begin n_fail++; $display("FAIL reset_coords: x=%0d y=%0d c=%0d expected 0 0 0", x_out, y_out, colour_out); end
        n_checks++; if ({dp_write, dp_draw, plot, done, err} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {dp_write, dp_draw, plot, done, err}); end
        n_checks++; if (dp_rest !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rest_ready: rest=%b ready=%b expected 1 0", dp_rest, req_ready); end
        resetn = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1 || dp_rest !== 1'b0) begin n_fail++; $display("FAIL post_reset: ready=%b rest=%b expected 1 0", req_ready, dp_rest); end
    endtask

    task automatic test_single_peg(input logic [3:0] row, input logic [1:0] slot,
                                   input logic [2:0] col, input logic [7:0] ex, input logic [6:0] ey);
        int draws = 0, bad_draw = 0, done_cyc = -1, done_cnt = 0, ready_bad = 0, rest_bad = 0;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL peg_ready_before: got %b expected 1", req_ready); end
        req_row = row; req_slot = slot; req_colour = col; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++; if (dp_write !== 1'b1 || dp_rest !== 1'b1 || dp_draw !== 1'b0) begin n_fail++; $display("FAIL peg_load: write=%b rest=%b draw=%b expected 1 1 0", dp_write, dp_rest, dp_draw); end
        n_checks++; if (x_out !== ex || y_out !== ey) begin n_fail++; $display("FAIL peg_coords: x=%0d y=%0d expected %0d %0d", x_out, y_out, ex, ey); end
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) tick();
            if (dp_draw) begin
                draws++;
                if (plot !== 1'b1 || colour_out !== col || dp_write || c < 2 || c > 17) bad_draw++;
            end else if (plot !== 1'b0) bad_draw++;
            if (done) begin done_cnt++; done_cyc = c; end
            if (c <= 18 && req_ready !== 1'b0) ready_bad++;
            if (c == 19 && req_ready !== 1'b1) ready_bad++;
            if (dp_rest !== (c == 1)) rest_bad++;
        end
        n_checks++; if (draws !== 16) begin n_fail++; $display("FAIL peg_draw_count: got %0d expected 16", draws); end
        n_checks++; if (bad_draw !== 0) begin n_fail++; $display("FAIL peg_draw_shape: %0d bad cycles expected 0", bad_draw); end
        n_checks++; if (done_cnt !== 1 || done_cyc !== 18) begin n_fail++; $display("FAIL peg_done: %0d pulses at cycle %0d expected 1 at 18", done_cnt, done_cyc); end
        n_checks++; if (ready_bad !== 0) begin n_fail++; $display("FAIL peg_ready_window: %0d bad cycles expected 0", ready_bad); end
        n_checks++; if (rest_bad !== 0) begin n_fail++; $display("FAIL peg_rest: %0d bad cycles expected 0", rest_bad); end
        n_checks++; if (x_out !== ex || y_out !== ey) begin n_fail++; $display("FAIL peg_coords_hold: x=%0d y=%0d expected %0d %0d", x_out, y_out, ex, ey); end
    endtask

    task automatic test_range_error();
        logic [7:0] px;
        logic [6:0] py;
        px = x_out; py = y_out;
        req_row = 4'd10; req_slot = 2'd1; req_colour = 3'd6; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++; if (err !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL err_pulse: err=%b ready=%b expected 1 0", err, req_ready); end
        n_checks++; if ({dp_write, dp_draw, plot} !== 3'b0) begin n_fail++; $display("FAIL err_strobes: got %b expected 000", {dp_write, dp_draw, plot}); end
        tick();
        n_checks++; if (err !== 1'b0 || req_ready !== 1'b1 || {dp_write, dp_draw, plot} !== 3'b0) begin n_fail++; $display("FAIL err_after: err=%b ready=%b strobes=%b expected 0 1 000", err, req_ready, {dp_write, dp_draw, plot}); end
        n_checks++; if (x_out !== px || y_out !== py || x_out !== 8'd26 || y_out !== 7'd67) begin n_fail++; $display("FAIL err_coords: x=%0d y=%0d expected 26 67", x_out, y_out); end
    endtask

    task automatic test_back_to_back();
        int load1 = -1, load2 = -1, loads = 0, dones = 0, first_bad = 0, second_bad = 0;
        req_row = 4'd1; req_slot = 2'd1; req_colour = 3'd2; req_valid = 1'b1;
        tick();
        for (int c = 1; c <= 45; c++) begin
            if (c > 1) tick();
            if (c == 3) begin req_row = 4'd2; req_slot = 2'd2; req_colour = 3'd5; end
            if (dp_write) begin
                loads++;
                if (load1 < 0) load1 = c; else if (load2 < 0) begin load2 = c; req_valid = 1'b0; end
            end
            if (done) dones++;
            if (c >= 2 && c <= 17 && (x_out !== 8'd14 || y_out !== 7'd11 || colour_out !== 3'd2 || !dp_draw)) first_bad++;
            if (c >= 21 && c <= 36 && (x_out !== 8'd20 || y_out !== 7'd18 || colour_out !== 3'd5 || !dp_draw)) second_bad++;
        end
        req_valid = 1'b0;
        n_checks++; if (load1 !== 1 || load2 !== 20) begin n_fail++; $display("FAIL b2b_load_cycles: %0d %0d expected 1 20", load1, load2); end
        n_checks++; if (loads !== 2 || dones !== 2) begin n_fail++; $display("FAIL b2b_counts: loads=%0d dones=%0d expected 2 2", loads, dones); end
        n_checks++; if (first_bad !== 0) begin n_fail++; $display("FAIL b2b_first_draw: %0d bad cycles expected 0", first_bad); end
        n_checks++; if (second_bad !== 0) begin n_fail++; $display("FAIL b2b_second_draw: %0d bad cycles expected 0", second_bad); end
    endtask

    task automatic test_reset_mid_draw();
        int dones = 0;
        req_row = 4'd0; req_slot = 2'd2; req_colour = 3'd7; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (7) tick();
        n_checks++; if (dp_draw !== 1'b1) begin n_fail++; $display("FAIL mid_draw_active: draw=%b expected 1", dp_draw); end
        resetn = 1'b0;
        #1;
        n_checks++; if (dp_rest !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_comb: rest=%b ready=%b expected 1 0", dp_rest, req_ready); end
        tick();
        n_checks++; if ({dp_draw, plot, done, dp_write} !== 4'b0 || x_out !== 8'd0) begin n_fail++; $display("FAIL mid_reset_abort: strobes=%b x=%0d expected 0000 0", {dp_draw, plot, done, dp_write}, x_out); end
        resetn = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_idle: ready=%b expected 1", req_ready); end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done || dp_draw) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: %0d activity cycles expected 0", dones); end
        test_single_peg(4'd0, 2'd2, 3'd7, 8'd20, 7'd4);
    endtask

    task automatic test_random();
        int exp_acc = 0, resp_bad = 0, timeouts = 0;
        logic bad;
        logic got;
        mon_plot = 0; mon_overlap = 0; mon_en = 1'b1;
        for (int r = 0; r < 200; r++) begin
            req_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            req_row = 4'($urandom_range(0, 11));
            req_slot = 2'($urandom_range(0, 3));
            req_colour = 3'($urandom_range(0, 7));
            req_valid = 1'b1;
            bad = (req_row >= 4'd10);
            if (!bad) exp_acc++;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                tick();
                if (dp_write || err) got = 1'b1;
            end
            req_valid = 1'b0;
            if (!got) timeouts++;
            else if (bad ? (err !== 1'b1 || dp_write !== 1'b0) : (dp_write !== 1'b1 || err !== 1'b0)) resp_bad++;
        end
        repeat (25) tick();
        mon_en = 1'b0;
        #1;
        n_checks++; if (timeouts !== 0) begin n_fail++; $display("FAIL rand_timeout: %0d requests unanswered expected 0", timeouts); end
        n_checks++; if (resp_bad !== 0) begin n_fail++; $display("FAIL rand_response: %0d wrong responses expected 0", resp_bad); end
        n_checks++; if (mon_plot !== 16 * exp_acc) begin n_fail++; $display("FAIL rand_plot_total: got %0d expected %0d", mon_plot, 16 * exp_acc); end
        n_checks++; if (mon_overlap !== 0) begin n_fail++; $display("FAIL rand_write_draw_overlap: got %0d expected 0", mon_overlap); end
    endtask

    initial begin
        test_reset();
        test_single_peg(4'd0, 2'd0, 3'b100, 8'd8, 7'd4);
        test_single_peg(4'd9, 2'd3, 3'b011, 8'd26, 7'd67);
        test_range_error();
        test_back_to_back();
        test_reset_mid_draw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
